// File: rtl/up_mem_initiator.sv
// up_mem_initiator: arbitrates fetch and data requesters onto the
// 8-bit up memory bus, one transaction at a time, with read timeout.
module up_mem_initiator #(
  parameter int unsigned TIMEOUT  = 8,
  parameter logic [7:0]  ERR_DATA = 8'hFF
) (
  input  logic       clk,
  input  logic       nRst,
  output logic [7:0] mem_address,
  output logic [7:0] mem_in,
  output logic       mem_we,
  input  logic [7:0] mem_out,
  input  logic       mem_re,
  input  logic       f_req,
  input  logic [7:0] f_addr,
  output logic       f_ack,
  output logic [7:0] f_data,
  input  logic       d_req,
  input  logic       d_we,
  input  logic [7:0] d_addr,
  input  logic [7:0] d_wdata,
  output logic       d_ack,
  output logic [7:0] d_rdata,
  output logic       err,
  output logic       busy
);

  localparam int CW =
    (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_MAX =
    CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    ACK
  } state_t;

  state_t        state_q;
  logic [7:0]    addr_q;
  logic [7:0]    wdata_q;
  logic          mem_we_q;
  logic          wr_q;
  logic          gnt_d_q;
  logic          last_d_q;
  logic [CW-1:0] cnt_q;
  logic          f_ack_q;
  logic          d_ack_q;
  logic [7:0]    f_data_q;
  logic [7:0]    d_rdata_q;
  logic          err_q;
  logic          busy_q;
  logic          pick_d_d;

  // Round robin: on contention the port not granted last wins.
  assign pick_d_d = d_req & (~f_req | ~last_d_q);

  always_ff @(posedge clk) begin
    if (!nRst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      mem_we_q  <= 1'b0;
      wr_q      <= 1'b0;
      gnt_d_q   <= 1'b0;
      last_d_q  <= 1'b0;
      cnt_q     <= '0;
      f_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      f_data_q  <= '0;
      d_rdata_q <= '0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (f_req | d_req) begin
            state_q  <= ACCESS;
            busy_q   <= 1'b1;
            gnt_d_q  <= pick_d_d;
            last_d_q <= pick_d_d;
            cnt_q    <= '0;
            if (pick_d_d) begin
              addr_q   <= d_addr;
              wdata_q  <= d_wdata;
              wr_q     <= d_we;
              mem_we_q <= d_we;
            end else begin
              addr_q   <= f_addr;
              wr_q     <= 1'b0;
              mem_we_q <= 1'b0;
            end
          end
        end
        ACCESS: begin
          if (wr_q) begin
            mem_we_q <= 1'b0;
            err_q    <= 1'b0;
            d_ack_q  <= 1'b1;
            state_q  <= ACK;
          end else if (mem_re) begin
            err_q   <= 1'b0;
            state_q <= ACK;
            if (gnt_d_q) begin
              d_rdata_q <= mem_out;
              d_ack_q   <= 1'b1;
            end else begin
              f_data_q <= mem_out;
              f_ack_q  <= 1'b1;
            end
          end else if (cnt_q == CNT_MAX) begin
            err_q   <= 1'b1;
            state_q <= ACK;
            if (gnt_d_q) begin
              d_rdata_q <= ERR_DATA;
              d_ack_q   <= 1'b1;
            end else begin
              f_data_q <= ERR_DATA;
              f_ack_q  <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ACK: begin
          f_ack_q  <= 1'b0;
          d_ack_q  <= 1'b0;
          mem_we_q <= 1'b0;
          cnt_q    <= '0;
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign mem_address = addr_q;
  assign mem_in      = wdata_q;
  assign mem_we      = mem_we_q;
  assign f_ack       = f_ack_q;
  assign f_data      = f_data_q;
  assign d_ack       = d_ack_q;
  assign d_rdata     = d_rdata_q;
  assign err         = err_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_up_mem_initiator.sv
// tb_up_mem_initiator: directed checks of arbitration, latency,
// wait states, timeout and reset behaviour against a memory model.
module tb_up_mem_initiator;

  logic       clk;
  logic       nRst;
  logic [7:0] mem_address;
  logic [7:0] mem_in;
  logic       mem_we;
  logic [7:0] mem_out;
  logic       mem_re;
  logic       f_req;
  logic [7:0] f_addr;
  logic       f_ack;
  logic [7:0] f_data;
  logic       d_req;
  logic       d_we;
  logic [7:0] d_addr;
  logic [7:0] d_wdata;
  logic       d_ack;
  logic [7:0] d_rdata;
  logic       err;
  logic       busy;

  int pass_cnt;
  int total_cnt;

  logic [7:0] mem [256];

  up_mem_initiator #(
    .TIMEOUT (8),
    .ERR_DATA(8'hFF)
  ) dut (
    .clk        (clk),
    .nRst       (nRst),
    .mem_address(mem_address),
    .mem_in     (mem_in),
    .mem_we     (mem_we),
    .mem_out    (mem_out),
    .mem_re     (mem_re),
    .f_req      (f_req),
    .f_addr     (f_addr),
    .f_ack      (f_ack),
    .f_data     (f_data),
    .d_req      (d_req),
    .d_we       (d_we),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_ack      (d_ack),
    .d_rdata    (d_rdata),
    .err        (err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_out = mem[mem_address];

  always @(posedge clk)
    if (mem_we) mem[mem_address] <= mem_in;

  // Drives one request from a negedge and waits for its ack.
  // lat counts negedges from request to ack (2 = zero wait).
  task automatic run_txn(
    input  bit         is_d,
    input  bit         we,
    input  logic [7:0] addr,
    input  logic [7:0] wd,
    input  int         re_wait,
    output int         lat,
    output int         we_cnt,
    output logic [7:0] we_addr,
    output logic [7:0] we_dat,
    output bit         other
  );
    lat = 0;
    we_cnt = 0;
    we_addr = 8'h00;
    we_dat = 8'h00;
    other = 1'b0;
    if (is_d) begin
      d_req = 1'b1;
      d_we = we;
      d_addr = addr;
      d_wdata = wd;
    end else begin
      f_req = 1'b1;
      f_addr = addr;
    end
    mem_re = (re_wait == 0);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (mem_we) begin
        we_cnt++;
        we_addr = mem_address;
        we_dat = mem_in;
      end
      if (is_d ? f_ack : d_ack) other = 1'b1;
      if (is_d ? d_ack : f_ack) begin
        lat = c;
        break;
      end
      mem_re = (c >= re_wait + 1);
    end
    f_req = 1'b0;
    d_req = 1'b0;
    mem_re = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    nRst = 1'b0;
    repeat (2) @(negedge clk);
    total_cnt++;
    if (busy !== 1'b0)
      $display("FAIL rst_busy: got %b want 0", busy);
    else pass_cnt++;
    total_cnt++;
    if ({f_ack, d_ack, err, mem_we} !== 4'b0000)
      $display("FAIL rst_flags: got %b want 0000",
               {f_ack, d_ack, err, mem_we});
    else pass_cnt++;
    total_cnt++;
    if ({mem_address, mem_in, f_data, d_rdata} !== 32'h0)
      $display("FAIL rst_data: got %h want 00000000",
               {mem_address, mem_in, f_data, d_rdata});
    else pass_cnt++;
    nRst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fetch();
    int lat, wc;
    logic [7:0] wa, wdv;
    bit oth;
    run_txn(1'b0, 1'b0, 8'h02, 8'h00, 0,
            lat, wc, wa, wdv, oth);
    total_cnt++;
    if (lat !== 2)
      $display("FAIL fetch_lat: got %0d want 2", lat);
    else pass_cnt++;
    total_cnt++;
    if (f_data !== 8'h6C)
      $display("FAIL fetch_data: got %h want 6c", f_data);
    else pass_cnt++;
    total_cnt++;
    if ({err, f_ack, oth} !== 3'b000)
      $display("FAIL fetch_err_pulse: got %b want 000",
               {err, f_ack, oth});
    else pass_cnt++;
  endtask

  task automatic test_store_load();
    int lat, wc;
    logic [7:0] wa, wdv;
    bit oth;
    run_txn(1'b1, 1'b1, 8'h20, 8'hA5, 0,
            lat, wc, wa, wdv, oth);
    total_cnt++;
    if (lat !== 2)
      $display("FAIL store_lat: got %0d want 2", lat);
    else pass_cnt++;
    total_cnt++;
    if (wc !== 1)
      $display("FAIL store_we_cycles: got %0d want 1", wc);
    else pass_cnt++;
    total_cnt++;
    if ({wa, wdv} !== 16'h20A5)
      $display("FAIL store_bus: got %h want 20a5", {wa, wdv});
    else pass_cnt++;
    total_cnt++;
    if ({err, oth, mem_we} !== 3'b000)
      $display("FAIL store_flags: got %b want 000",
               {err, oth, mem_we});
    else pass_cnt++;
    run_txn(1'b1, 1'b0, 8'h20, 8'h00, 0,
            lat, wc, wa, wdv, oth);
    total_cnt++;
    if (d_rdata !== 8'hA5 || lat !== 2)
      $display("FAIL load_back: got %h/%0d want a5/2",
               d_rdata, lat);
    else pass_cnt++;
    total_cnt++;
    if (wc !== 0 || f_data !== 8'h6C)
      $display("FAIL load_side: got %0d/%h want 0/6c",
               wc, f_data);
    else pass_cnt++;
  endtask

  task automatic test_wait_states();
    int lat, wc;
    logic [7:0] wa, wdv;
    bit oth;
    run_txn(1'b1, 1'b0, 8'h08, 8'h00, 3,
            lat, wc, wa, wdv, oth);
    total_cnt++;
    if (lat !== 5)
      $display("FAIL wait_lat: got %0d want 5", lat);
    else pass_cnt++;
    total_cnt++;
    if (d_rdata !== 8'hBB || err !== 1'b0)
      $display("FAIL wait_data: got %h/%b want bb/0",
               d_rdata, err);
    else pass_cnt++;
  endtask

  task automatic test_timeout();
    int lat, wc;
    logic [7:0] wa, wdv;
    bit oth;
    run_txn(1'b0, 1'b0, 8'h04, 8'h00, 100,
            lat, wc, wa, wdv, oth);
    total_cnt++;
    if (lat !== 9)
      $display("FAIL to_lat: got %0d want 9", lat);
    else pass_cnt++;
    total_cnt++;
    if (f_data !== 8'hFF || err !== 1'b1)
      $display("FAIL to_data: got %h/%b want ff/1",
               f_data, err);
    else pass_cnt++;
    repeat (3) @(negedge clk);
    total_cnt++;
    if (err !== 1'b1 || d_rdata !== 8'hBB)
      $display("FAIL to_hold: got %b/%h want 1/bb",
               err, d_rdata);
    else pass_cnt++;
    run_txn(1'b0, 1'b0, 8'h02, 8'h00, 0,
            lat, wc, wa, wdv, oth);
    total_cnt++;
    if (err !== 1'b0 || f_data !== 8'h6C || lat !== 2)
      $display("FAIL to_recover: got %b/%h/%0d want 0/6c/2",
               err, f_data, lat);
    else pass_cnt++;
  endtask

  task automatic test_contention();
    int n;
    int t[4];
    bit k[4];
    bit ovl;
    n = 0;
    ovl = 1'b0;
    nRst = 1'b0;
    f_req = 1'b1;
    f_addr = 8'h02;
    d_req = 1'b1;
    d_we = 1'b0;
    d_addr = 8'h08;
    mem_re = 1'b1;
    @(negedge clk);
    nRst = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (f_ack && d_ack) ovl = 1'b1;
      if (f_ack || d_ack) begin
        t[n] = c;
        k[n] = d_ack;
        n++;
        if (n == 4) begin
          f_req = 1'b0;
          d_req = 1'b0;
          break;
        end
      end
    end
    @(negedge clk);
    total_cnt++;
    if (n !== 4)
      $display("FAIL cont_count: got %0d want 4", n);
    else pass_cnt++;
    if (n == 4) begin
      total_cnt++;
      if ({k[0], k[1], k[2], k[3]} !== 4'b1010)
        $display("FAIL cont_order: got %b want 1010",
                 {k[0], k[1], k[2], k[3]});
      else pass_cnt++;
      total_cnt++;
      if (t[0] !== 2 || t[1] - t[0] !== 3 ||
          t[2] - t[1] !== 3 || t[3] - t[2] !== 3)
        $display("FAIL cont_spacing: got %0d,%0d,%0d,%0d want 2,5,8,11",
                 t[0], t[1], t[2], t[3]);
      else pass_cnt++;
    end
    total_cnt++;
    if (ovl !== 1'b0 || f_data !== 8'h6C || d_rdata !== 8'hBB)
      $display("FAIL cont_data: got %b/%h/%h want 0/6c/bb",
               ovl, f_data, d_rdata);
    else pass_cnt++;
  endtask

  task automatic test_reset_midop();
    int lat;
    bit first_d;
    d_req = 1'b1;
    d_we = 1'b1;
    d_addr = 8'h30;
    d_wdata = 8'h11;
    @(negedge clk);
    total_cnt++;
    if (busy !== 1'b1 || mem_we !== 1'b1)
      $display("FAIL midop_access: got %b%b want 11",
               busy, mem_we);
    else pass_cnt++;
    nRst = 1'b0;
    d_req = 1'b0;
    @(negedge clk);
    total_cnt++;
    if ({busy, mem_we, d_ack, f_ack} !== 4'b0000 ||
        mem_address !== 8'h00 || mem_in !== 8'h00)
      $display("FAIL midop_reset: got %b/%h/%h want 0000/00/00",
               {busy, mem_we, d_ack, f_ack}, mem_address, mem_in);
    else pass_cnt++;
    nRst = 1'b1;
    repeat (2) @(negedge clk);
    total_cnt++;
    if ({busy, d_ack, f_ack} !== 3'b000)
      $display("FAIL midop_noack: got %b want 000",
               {busy, d_ack, f_ack});
    else pass_cnt++;
    f_req = 1'b1;
    f_addr = 8'h02;
    d_req = 1'b1;
    d_we = 1'b0;
    d_addr = 8'h08;
    lat = 0;
    first_d = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (f_ack || d_ack) begin
        lat = c;
        first_d = d_ack;
        break;
      end
    end
    f_req = 1'b0;
    d_req = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (first_d !== 1'b1 || lat !== 2)
      $display("FAIL midop_first_grant: got %b/%0d want 1/2",
               first_d, lat);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt = 0;
    total_cnt = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    mem[8'h02] = 8'h6C;
    mem[8'h08] = 8'hBB;
    nRst = 1'b0;
    f_req = 1'b0;
    f_addr = 8'h00;
    d_req = 1'b0;
    d_we = 1'b0;
    d_addr = 8'h00;
    d_wdata = 8'h00;
    mem_re = 1'b1;
    @(negedge clk);
    test_reset();
    test_fetch();
    test_store_load();
    test_wait_states();
    test_timeout();
    test_contention();
    test_reset_midop();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
